// File: rtl/gtxe2_chnl_tx_oob_pkg.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_tx_oob_pkg
// Shared SATA OOB constants for the GTXE2 channel TX generator and the RX
// OOB detector.
// Contents:
//   - default burst/gap lengths and the RX acceptance windows
//   - number of bursts per OOB sequence
//   - FSM state encoding of the TX OOB generator
// No ports (package).
// ---------------------------------------------------------------------------
package gtxe2_chnl_tx_oob_pkg;

    // Default lengths in TX clock cycles.
    localparam int OOB_BURST_LEN     = 160;
    localparam int OOB_WAKE_IDLE_LEN = 160;
    localparam int OOB_INIT_IDLE_LEN = 480;
    localparam int OOB_SAS_IDLE_LEN  = 1440;
    localparam int OOB_BURSTS_NUM    = 6;
    localparam int OOB_CNT_W         = 12;

    // RX acceptance windows, half-open [min, max).
    localparam int RX_BURST_MIN = 150;
    localparam int RX_BURST_MAX = 340;
    localparam int RX_WAKE_MIN  = 150;
    localparam int RX_WAKE_MAX  = 340;
    localparam int RX_INIT_MIN  = 450;
    localparam int RX_INIT_MAX  = 990;
    localparam int RX_BURSTS_MIN = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } oob_state_t;

endpackage

// File: rtl/gtxe2_chnl_tx_oob_if.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_tx_oob_if
// Request/response and line signals of the TX OOB generator.
//   TXELECIDLE  : must stay 1 for the whole sequence
//   TXCOMINIT   : single-cycle COMINIT/COMRESET request
//   TXCOMWAKE   : single-cycle COMWAKE request
//   TXCOMSAS    : single-cycle COMSAS request (only with GTXE2_TX_OOB_COMSAS_EN)
//   TXCOMFINISH : one-cycle pulse when a sequence completes
//   oob_active  : 1 while a burst or gap is driven (TX mux select)
//   oob_p/oob_n : line values while oob_active=1
// Modports: master = requester (PCS side / bench), slave = generator.
// ---------------------------------------------------------------------------
interface gtxe2_chnl_tx_oob_if;
    logic TXELECIDLE;
    logic TXCOMINIT;
    logic TXCOMWAKE;
`ifdef GTXE2_TX_OOB_COMSAS_EN
    logic TXCOMSAS;
`endif
    logic TXCOMFINISH;
    logic oob_active;
    logic oob_p;
    logic oob_n;

    modport master (
        output TXELECIDLE, TXCOMINIT, TXCOMWAKE,
`ifdef GTXE2_TX_OOB_COMSAS_EN
        output TXCOMSAS,
`endif
        input  TXCOMFINISH, oob_active, oob_p, oob_n
    );

    modport slave (
        input  TXELECIDLE, TXCOMINIT, TXCOMWAKE,
`ifdef GTXE2_TX_OOB_COMSAS_EN
        input  TXCOMSAS,
`endif
        output TXCOMFINISH, oob_active, oob_p, oob_n
    );
endinterface

// File: rtl/gtxe2_chnl_oob_timer.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_oob_timer
// CNT_W-bit up-counter used to time bursts and gaps.
//   clk     in  : clock
//   reset_n in  : asynchronous active-low reset
//   clr     in  : synchronous clear (count restarts at 0 next cycle)
//   len     in  : current interval length
//   done    out : cnt == len-1 (last cycle of the interval)
// The count holds at len-1 instead of wrapping if clr is not asserted.
// ---------------------------------------------------------------------------
module gtxe2_chnl_oob_timer #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] len,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = (cnt_q == len - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/gtxe2_chnl_tx_oob.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_tx_oob
// SATA OOB signal generator for the GTXE2 channel TX path. On a COMINIT or
// COMWAKE request (and COMSAS when GTXE2_TX_OOB_COMSAS_EN is defined) it
// drives BURSTS_NUM bursts of TXP/TXN toggling, each followed by an
// electrical-idle gap of the request's length, then pulses TXCOMFINISH.
// Ports:
//   clk     in : channel TX clock
//   reset_n in : asynchronous active-low reset
//   bus        : gtxe2_chnl_tx_oob_if.slave (requests in, line/status out)
// Optional feature macro: GTXE2_TX_OOB_COMSAS_EN (adds TXCOMSAS, priority
// INIT > SAS > WAKE).
// ---------------------------------------------------------------------------
module gtxe2_chnl_tx_oob
    import gtxe2_chnl_tx_oob_pkg::*;
#(
    parameter int BURST_LEN     = OOB_BURST_LEN,
    parameter int WAKE_IDLE_LEN = OOB_WAKE_IDLE_LEN,
    parameter int INIT_IDLE_LEN = OOB_INIT_IDLE_LEN,
`ifdef GTXE2_TX_OOB_COMSAS_EN
    parameter int SAS_IDLE_LEN  = OOB_SAS_IDLE_LEN,
`endif
    parameter int BURSTS_NUM    = OOB_BURSTS_NUM,
    parameter int CNT_W         = OOB_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gtxe2_chnl_tx_oob_if.slave    bus
);
    localparam int BCNT_W = $clog2(BURSTS_NUM + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURSTS_NUM);
    localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  WAKE_C    = CNT_W'(WAKE_IDLE_LEN);
    localparam logic [CNT_W-1:0]  INIT_C    = CNT_W'(INIT_IDLE_LEN);
`ifdef GTXE2_TX_OOB_COMSAS_EN
    localparam logic [CNT_W-1:0]  SAS_C     = CNT_W'(SAS_IDLE_LEN);
`endif

    oob_state_t        state_q, state_d;
    logic [CNT_W-1:0]  sel_len_q, sel_len_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              tog_q, tog_d;
    logic [CNT_W-1:0]  tim_len;
    logic              tim_clr;
    logic              tim_done;

    gtxe2_chnl_oob_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tim_clr),
        .len     (tim_len),
        .done    (tim_done)
    );

    always_comb begin
        state_d   = state_q;
        sel_len_d = sel_len_q;
        bcnt_d    = bcnt_q;
        tog_d     = 1'b0;
        tim_len   = BURST_C;
        case (state_q)
            ST_IDLE: begin
                bcnt_d = '0;
                if (bus.TXELECIDLE) begin
                    if (bus.TXCOMINIT) begin
                        state_d   = ST_BURST;
                        sel_len_d = INIT_C;
`ifdef GTXE2_TX_OOB_COMSAS_EN
                    end else if (bus.TXCOMSAS) begin
                        state_d   = ST_BURST;
                        sel_len_d = SAS_C;
`endif
                    end else if (bus.TXCOMWAKE) begin
                        state_d   = ST_BURST;
                        sel_len_d = WAKE_C;
                    end
                end
                // Each burst starts with oob_p=1.
                tog_d = (state_d == ST_BURST);
            end
            ST_BURST: begin
                tog_d = ~tog_q;
                if (!bus.TXELECIDLE) begin
                    state_d = ST_IDLE;
                end else if (tim_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                tim_len = sel_len_q;
                if (!bus.TXELECIDLE) begin
                    state_d = ST_IDLE;
                end else if (tim_done) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                    if (bcnt_d == BCNT_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_BURST;
                        tog_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Timer restarts on every state change and stays clear outside
        // the timed states.
        tim_clr = (state_d != state_q) ||
                  !((state_q == ST_BURST) || (state_q == ST_GAP));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sel_len_q <= '0;
            bcnt_q    <= '0;
            tog_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_len_q <= sel_len_d;
            bcnt_q    <= bcnt_d;
            tog_q     <= tog_d;
        end
    end

    // Outputs decode directly from state so a reset clears them at once.
    assign bus.TXCOMFINISH = (state_q == ST_FINISH);
    assign bus.oob_active  = (state_q == ST_BURST) || (state_q == ST_GAP);
    assign bus.oob_p       = (state_q == ST_BURST) &&  tog_q;
    assign bus.oob_n       = (state_q == ST_BURST) && !tog_q;
endmodule
